// File: rtl/cpu_pkg.sv
// Purpose: shared opcodes, condition codes and FSM state encoding for the CPU sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

  // Opcodes 0x0-0xB are ALU operations and pass straight through as ALU_OP.
  localparam logic [3:0] OP_LD  = 4'hC;
  localparam logic [3:0] OP_ST  = 4'hD;
  localparam logic [3:0] OP_BR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // The ALU passes R through unchanged, which puts the branch target on Alu_out.
  localparam logic [3:0] ALU_PASS_R = 4'h0;

  // Branch condition field IR[11:9]; 110 and 111 never branch.
  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_NZ = 3'b010;
  localparam logic [2:0] CC_N  = 3'b011;
  localparam logic [2:0] CC_C  = 3'b100;
  localparam logic [2:0] CC_NC = 3'b101;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ALU    = 3'd3,
    LOAD   = 3'd4,
    STORE  = 3'd5,
    BRANCH = 3'd6,
    HALT   = 3'd7
  } state_t;

endpackage

// File: rtl/cpu_branch_eval.sv
// Purpose: decides whether a branch is taken from the condition field and the ALU flags.
// Latency: combinational, zero cycles.
// Backpressure: none; the output is a pure function of the inputs.
// Ports: cond (IR[11:9]), C/N/Z flags in; taken out.
module cpu_branch_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       C,
  input  logic       N,
  input  logic       Z,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL:   taken = 1'b1;
      CC_Z:    taken = Z;
      CC_NZ:   taken = ~Z;
      CC_N:    taken = N;
      CC_C:    taken = C;
      CC_NC:   taken = ~C;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Purpose: multi-cycle fetch/decode/execute sequencer driving every datapath and memory strobe.
// Latency: FETCH and DECODE take 1 cycle each, then one execute cycle; 3 cycles per instruction.
// Backpressure: none on memory; the only stall is HALT, which waits for go.
// Ports: clk, reset (async, active-high); IR_out, C/N/Z, go in;
//        pc_ld, pc_inc, ir_ld, reg_w_en, s_sel, adr_sel, mem_rd, mem_wr,
//        W_Adr/R_Adr/S_Adr, ALU_OP, halted out. All outputs are Moore-decoded
//        from state and IR_out; pc_ld alone also sees the flags (BRANCH only).
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int RADR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] IR_out,
  input  logic              C,
  input  logic              N,
  input  logic              Z,
  input  logic              go,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              ir_ld,
  output logic              reg_w_en,
  output logic              s_sel,
  output logic              adr_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [RADR_W-1:0] W_Adr,
  output logic [RADR_W-1:0] R_Adr,
  output logic [RADR_W-1:0] S_Adr,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              halted
);

  state_t state, next_state;

  logic [OP_W-1:0]   opcode;
  logic [2:0]        cond;
  logic [RADR_W-1:0] ir_dest, ir_r, ir_s;
  logic              br_taken;

  assign opcode  = IR_out[15:12];
  assign cond    = IR_out[11:9];
  assign ir_dest = IR_out[8:6];
  assign ir_r    = IR_out[5:3];
  assign ir_s    = IR_out[2:0];

  cpu_branch_eval u_branch_eval (
    .cond  (cond),
    .C     (C),
    .N     (N),
    .Z     (Z),
    .taken (br_taken)
  );

  // Reset is asynchronous into the state register; since every output is
  // decoded from state, strobes drop the moment reset rises and no write
  // strobe survives into the aborted instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    ir_ld      = 1'b0;
    reg_w_en   = 1'b0;
    s_sel      = 1'b0;
    adr_sel    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    ALU_OP     = '0;
    // Address outputs follow the IR fields in every live state so they stay
    // stable even where nobody consumes them.
    W_Adr      = ir_dest;
    R_Adr      = ir_r;
    S_Adr      = ir_s;

    case (state)
      RESET: begin
        W_Adr      = '0;
        R_Adr      = '0;
        S_Adr      = '0;
        next_state = FETCH;
      end
      FETCH: begin
        mem_rd     = 1'b1;
        ir_ld      = 1'b1;
        pc_inc     = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LD:   next_state = LOAD;
          OP_ST:   next_state = STORE;
          OP_BR:   next_state = BRANCH;
          OP_HLT:  next_state = HALT;
          default: next_state = ALU;
        endcase
      end
      ALU: begin
        ALU_OP     = opcode;
        reg_w_en   = 1'b1;
        next_state = FETCH;
      end
      LOAD: begin
        adr_sel    = 1'b1;
        mem_rd     = 1'b1;
        s_sel      = 1'b1;
        reg_w_en   = 1'b1;
        next_state = FETCH;
      end
      STORE: begin
        adr_sel    = 1'b1;
        mem_wr     = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALU_OP     = ALU_PASS_R;
        pc_ld      = br_taken;
        next_state = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (go) next_state = FETCH;
      end
      default: next_state = RESET;
    endcase
  end

endmodule
